cmd_respond_tlb: RTL and testbench

CMD_RESPOND_TLB -- requirements
Module: cmd_respond_tlb

---
 rtl/cmd_respond_pkg.sv | 17 +
 rtl/cmd_respond_ram.sv | 21 ++
 rtl/cmd_respond_tlb.sv | 151 +++++++++++++++
 tb/tb_cmd_respond_tlb.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_respond_pkg.sv
// Shared constants and types for the command/response register-file responder.
package cmd_respond_pkg;

  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] RSP_ACK  = 8'h4B;
  localparam logic [7:0] RSP_ERR  = 8'h3F;

  typedef enum logic [1:0] {IDLE, EXEC, SEND, WAIT} state_t;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] addr;
    logic [7:0] wdata;
  } cmd_t;

endpackage

// File: rtl/cmd_respond_ram.sv
// Register file: one write port, combinational read, contents never reset.
module cmd_respond_ram #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] regs [DEPTH];

  always_ff @(posedge clk)
    if (we) regs[addr] <= wdata;

  assign rdata = regs[addr];

endmodule

// File: rtl/cmd_respond_tlb.sv
// Pops commands from a FWFT FIFO, executes reads/writes on a register file and
// answers with one UART byte per command; CMD_RESPOND_ECHO_EN prefixes an address echo.
module cmd_respond_tlb
  import cmd_respond_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int DATA_W      = 8,
  parameter int FRAME_TICKS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [23:0]       cmd_fifo_rd_data,
  input  logic              cmd_fifo_valid,
  output logic              cmd_fifo_rd_en,
  input  logic              baud_tick,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_data_en
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [CW-1:0] LAST_TICK = CW'(FRAME_TICKS - 1);

  state_t            state;
  cmd_t              cmd_q;
  logic [CW-1:0]     tick_cnt;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] rsp;
  logic              we;
  logic              in_range;

  assign in_range = ({24'd0, cmd_q.addr} < 32'(DEPTH));

  // Write strobe only in EXEC and not under reset, so a reset in EXEC drops the write.
  always_comb begin
    rsp = DATA_W'(RSP_ERR);
    we  = 1'b0;
    if (in_range) begin
      if (cmd_q.op == OP_READ) begin
        rsp = rd_data;
      end else if (cmd_q.op == OP_WRITE) begin
        rsp = DATA_W'(RSP_ACK);
        we  = (state == EXEC) && rst;
      end
    end
  end

  cmd_respond_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) ram (
    .clk   (clk),
    .we    (we),
    .addr  (cmd_q.addr[AW-1:0]),
    .wdata (DATA_W'(cmd_q.wdata)),
    .rdata (rd_data)
  );

`ifdef CMD_RESPOND_ECHO_EN
  logic [DATA_W-1:0] rsp_q;
  logic              echo_pend;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      cmd_q          <= '0;
      rsp_q          <= '0;
      echo_pend      <= 1'b0;
      tick_cnt       <= '0;
      cmd_fifo_rd_en <= 1'b0;
      tx_data_en     <= 1'b0;
      tx_data        <= '0;
    end else begin
      cmd_fifo_rd_en <= 1'b0;
      tx_data_en     <= 1'b0;
      case (state)
        IDLE: if (cmd_fifo_valid) begin
          cmd_q          <= cmd_fifo_rd_data;
          cmd_fifo_rd_en <= 1'b1;
          state          <= EXEC;
        end
        EXEC: begin
          rsp_q      <= rsp;
          echo_pend  <= 1'b1;
          tx_data    <= DATA_W'(cmd_q.addr);
          tx_data_en <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          tick_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: if (baud_tick) begin
          if (tick_cnt == LAST_TICK) begin
            tick_cnt <= '0;
            if (echo_pend) begin
              echo_pend  <= 1'b0;
              tx_data    <= rsp_q;
              tx_data_en <= 1'b1;
              state      <= SEND;
            end else begin
              state <= IDLE;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      cmd_q          <= '0;
      tick_cnt       <= '0;
      cmd_fifo_rd_en <= 1'b0;
      tx_data_en     <= 1'b0;
      tx_data        <= '0;
    end else begin
      cmd_fifo_rd_en <= 1'b0;
      tx_data_en     <= 1'b0;
      case (state)
        IDLE: if (cmd_fifo_valid) begin
          cmd_q          <= cmd_fifo_rd_data;
          cmd_fifo_rd_en <= 1'b1;
          state          <= EXEC;
        end
        EXEC: begin
          tx_data    <= rsp;
          tx_data_en <= 1'b1;
          state      <= SEND;
        end
        // Counting starts in WAIT, so a tick during the strobe cycle is ignored.
        SEND: begin
          tick_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: if (baud_tick) begin
          if (tick_cnt == LAST_TICK) begin
            tick_cnt <= '0;
            state    <= IDLE;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_cmd_respond_tlb.sv
// Directed bench for cmd_respond_tlb; honours CMD_RESPOND_ECHO_EN when defined.
module tb_cmd_respond_tlb;

  logic        clk;
  logic        rst;
  logic [23:0] cmd_fifo_rd_data;
  logic        cmd_fifo_valid;
  logic        cmd_fifo_rd_en;
  logic        baud_tick;
  logic [7:0]  tx_data;
  logic        tx_data_en;

  logic        tick_auto, tick_man, auto_tick;
  int          tc;
  int          n_cmp, n_err;
  logic [7:0]  mdl [16];

  cmd_respond_tlb #(.DEPTH(16), .DATA_W(8), .FRAME_TICKS(10)) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_fifo_rd_data (cmd_fifo_rd_data),
    .cmd_fifo_valid   (cmd_fifo_valid),
    .cmd_fifo_rd_en   (cmd_fifo_rd_en),
    .baud_tick        (baud_tick),
    .tx_data          (tx_data),
    .tx_data_en       (tx_data_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running tick every 868 cycles, updated just after the rising edge.
  always @(posedge clk) begin
    #2;
    if (tick_auto) begin
      tc = (tc == 867) ? 0 : tc + 1;
      auto_tick = (tc == 0);
    end else begin
      tc = 0;
      auto_tick = 1'b0;
    end
  end

  assign baud_tick = tick_auto ? auto_tick : tick_man;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) tick_man = 1'b1;
      @(negedge clk) tick_man = 1'b0;
    end
  endtask

  // Issue one command to an idle DUT; returns at the negedge of the response strobe.
  task automatic cmd(input logic [23:0] c, input logic [7:0] exp, input string tag);
    int lat;
    lat = 0;
    cmd_fifo_rd_data = c;
    cmd_fifo_valid = 1'b1;
    while (lat < 50 && !cmd_fifo_rd_en) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_rd_lat"}, 32'(lat), 32'd1);
    cmd_fifo_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_rd_once"}, 32'(cmd_fifo_rd_en), 32'd0);
    chk({tag, "_strobe"}, 32'(tx_data_en), 32'd1);
`ifdef CMD_RESPOND_ECHO_EN
    chk({tag, "_echo"}, 32'(tx_data), 32'(c[15:8]));
    ticks(10);
    chk({tag, "_strobe2"}, 32'(tx_data_en), 32'd1);
`endif
    chk({tag, "_data"}, 32'(tx_data), 32'(exp));
  endtask

  task automatic finish_frame(input logic [7:0] exp, input string tag);
    ticks(10);
    chk({tag, "_hold"}, 32'(tx_data), 32'(exp));
    chk({tag, "_quiet"}, 32'(tx_data_en), 32'd0);
  endtask

  initial begin
    int nt, nrd, cyc;
    logic [7:0] e1, e2;
    n_cmp = 0; n_err = 0;
    rst = 1'b0; cmd_fifo_valid = 1'b0; cmd_fifo_rd_data = '0;
    tick_auto = 1'b0; tick_man = 1'b0; auto_tick = 1'b0; tc = 0;
    repeat (3) @(negedge clk);
    chk("rst_rd_en", 32'(cmd_fifo_rd_en), 32'd0);
    chk("rst_tx_en", 32'(tx_data_en), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);

    for (int i = 0; i < 16; i++) mdl[i] = 8'h10 + 8'(i);
    mdl[3] = 8'hA5;
    for (int i = 0; i < 16; i++) dut.ram.regs[i] = mdl[i];
    rst = 1'b1;
    @(negedge clk);

    cmd(24'h520300, 8'hA5, "rd3");
    finish_frame(8'hA5, "rd3");

    cmd(24'h57053C, 8'h4B, "wr5");
    mdl[5] = 8'h3C;
    chk("wr5_reg", 32'(dut.ram.regs[5]), 32'h3C);
    finish_frame(8'h4B, "wr5");
    cmd(24'h520500, 8'h3C, "rd5");
    finish_frame(8'h3C, "rd5");

    cmd(24'h001122, 8'h3F, "badop");
    finish_frame(8'h3F, "badop");
    cmd(24'h521000, 8'h3F, "badaddr");
    finish_frame(8'h3F, "badaddr");
    cmd(24'h571099, 8'h3F, "badwr");
    finish_frame(8'h3F, "badwr");

    // Tick during the strobe must not count; nine more leave the DUT waiting.
    cmd(24'h520300, 8'hA5, "coin");
    tick_man = 1'b1;
    @(negedge clk) tick_man = 1'b0;
    ticks(9);
    cmd_fifo_rd_data = 24'h570A77;
    cmd_fifo_valid = 1'b1;
    nrd = 0;
    repeat (4) begin
      @(negedge clk);
      if (cmd_fifo_rd_en) nrd++;
    end
    chk("coin_no_early_rd", 32'(nrd), 32'd0);
    tick_man = 1'b1;
    @(negedge clk) tick_man = 1'b0;
    chk("coin_idle_rd", 32'(cmd_fifo_rd_en), 32'd0);
    @(negedge clk);
    chk("coin_rd", 32'(cmd_fifo_rd_en), 32'd1);
    cmd_fifo_valid = 1'b0;
    @(negedge clk);
    chk("coin2_strobe", 32'(tx_data_en), 32'd1);
`ifdef CMD_RESPOND_ECHO_EN
    chk("coin2_echo", 32'(tx_data), 32'h0A);
    ticks(10);
    chk("coin2_strobe2", 32'(tx_data_en), 32'd1);
`endif
    chk("coin2_data", 32'(tx_data), 32'h4B);
    mdl[10] = 8'h77;
    finish_frame(8'h4B, "coin2");

    // Two queued commands under a real-rate baud tick.
`ifdef CMD_RESPOND_ECHO_EN
    e1 = 8'h03; e2 = 8'hA5;
`else
    e1 = 8'hA5; e2 = 8'h3C;
`endif
    tick_auto = 1'b1;
    cmd_fifo_rd_data = 24'h520300;
    cmd_fifo_valid = 1'b1;
    cyc = 0;
    while (cyc < 50 && !cmd_fifo_rd_en) begin @(negedge clk); cyc++; end
    chk("q_first_rd", 32'(cmd_fifo_rd_en), 32'd1);
    cmd_fifo_rd_data = 24'h520500;
    cyc = 0;
    while (cyc < 50 && !tx_data_en) begin @(negedge clk); cyc++; end
    chk("q_first_strobe", 32'(tx_data_en), 32'd1);
    chk("q_first_data", 32'(tx_data), 32'(e1));
    nt = 0; nrd = 0; cyc = 0;
    while (cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (tx_data_en) break;
      if (baud_tick) nt++;
      if (cmd_fifo_rd_en) begin nrd++; cmd_fifo_valid = 1'b0; end
    end
    chk("q_second_strobe", 32'(tx_data_en), 32'd1);
    chk("q_tick_gap", 32'(nt), 32'd10);
`ifdef CMD_RESPOND_ECHO_EN
    chk("q_pops_between", 32'(nrd), 32'd0);
`else
    chk("q_pops_between", 32'(nrd), 32'd1);
`endif
    chk("q_second_data", 32'(tx_data), 32'(e2));

    // Reset while waiting out the frame.
    cmd_fifo_valid = 1'b0;
    repeat (3) @(negedge clk);
    tick_auto = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("wrst_rd_en", 32'(cmd_fifo_rd_en), 32'd0);
    chk("wrst_tx_en", 32'(tx_data_en), 32'd0);
    chk("wrst_tx_data", 32'(tx_data), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    cmd(24'h520500, 8'h3C, "post_rst");
    finish_frame(8'h3C, "post_rst");

    // Reset during EXEC must drop the write and the response.
    cmd_fifo_rd_data = 24'h5707EE;
    cmd_fifo_valid = 1'b1;
    cyc = 0;
    while (cyc < 50 && !cmd_fifo_rd_en) begin @(negedge clk); cyc++; end
    chk("xrst_rd", 32'(cmd_fifo_rd_en), 32'd1);
    rst = 1'b0;
    cmd_fifo_valid = 1'b0;
    @(negedge clk);
    chk("xrst_no_strobe", 32'(tx_data_en), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("xrst_no_strobe2", 32'(tx_data_en), 32'd0);

    for (int i = 0; i < 16; i++)
      chk($sformatf("reg%0d", i), 32'(dut.ram.regs[i]), 32'(mdl[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
